// File: rtl/processor_status_stack_pkg.sv
// Shared definitions for the eco32 processor status word.
// Write source codes and field offset helpers.
package processor_status_stack_pkg;

  localparam int PSW_WRITE_DATA_SOURCE_WIDTH = 3;

  typedef enum logic [PSW_WRITE_DATA_SOURCE_WIDTH-1:0] {
    SRC_EXPLICIT   = 3'd0,
    SRC_ENTRY      = 3'd1,
    SRC_EXIT       = 3'd2,
    SRC_MASK_SET   = 3'd3,
    SRC_MASK_CLEAR = 3'd4
  } pswSource_e;

  function automatic int priorityLsb(
    input int maskWidth
  );
    return maskWidth;
  endfunction

  function automatic int ieLsb(
    input int maskWidth,
    input int prioWidth
  );
    return maskWidth + prioWidth;
  endfunction

  function automatic int uLsb(
    input int maskWidth,
    input int prioWidth,
    input int depth
  );
    return maskWidth + prioWidth + depth;
  endfunction

  function automatic int vBitPos(
    input int maskWidth,
    input int prioWidth,
    input int depth
  );
    return maskWidth + prioWidth + 2 * depth;
  endfunction

endpackage

// File: rtl/psw_mode_stack.sv
// One mode stack of the PSW; MSB is the current level.
// Push shifts a 0 in at the top, pop duplicates the oldest bit.
module psw_mode_stack #(
  parameter int DEPTH = 3
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [DEPTH-1:0] loadValue,
  input  logic             push,
  input  logic             pop,
  output logic [DEPTH-1:0] value
);

  logic [DEPTH-1:0] pushed;
  logic [DEPTH-1:0] popped;

  if (DEPTH == 1) begin : gSingle
    assign pushed = '0;
    assign popped = value;
  end else begin : gMulti
    assign pushed = {1'b0, value[DEPTH-1:1]};
    assign popped = {value[DEPTH-2:0], value[0]};
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      value <= '0;
    end else if (load) begin
      value <= loadValue;
    end else if (push) begin
      value <= pushed;
    end else if (pop) begin
      value <= popped;
    end
  end

endmodule

// File: rtl/processor_status_stack.sv
// eco32 processor status word with mode stacks, priority, mask
// and a handler nesting counter with sticky overflow/underflow flags.
module processor_status_stack
  import processor_status_stack_pkg::*;
#(
  parameter int STACK_DEPTH    = 3,
  parameter int PRIORITY_WIDTH = 5,
  parameter int MASK_WIDTH     = 16,
  parameter int DATA_WIDTH     = 32
) (
  input  logic                   clock,
  input  logic                   reset,
  output logic [DATA_WIDTH-1:0]  readValue,
  input  logic                   writeEnable,
  input  logic [2:0]             writeDataSource,
  input  logic [DATA_WIDTH-1:0]  explicitWriteValue,
  input  logic [PRIORITY_WIDTH-1:0] priorityWriteValue,
  input  logic                   flagClear,
  output logic [$clog2(STACK_DEPTH+1)-1:0] nestingLevel,
  output logic                   nestingOverflow,
  output logic                   nestingUnderflow
);

  localparam int LW = $clog2(STACK_DEPTH + 1);
  localparam int PL = priorityLsb(MASK_WIDTH);
  localparam int IL = ieLsb(MASK_WIDTH, PRIORITY_WIDTH);
  localparam int UL = uLsb(MASK_WIDTH, PRIORITY_WIDTH, STACK_DEPTH);
  localparam int VP = vBitPos(MASK_WIDTH, PRIORITY_WIDTH, STACK_DEPTH);

  if (DATA_WIDTH < VP + 1) begin : gWidthCheck
    $error("DATA_WIDTH too small for PSW layout");
  end

  if (STACK_DEPTH < 1 || STACK_DEPTH > 8) begin : gDepthCheck
    $error("STACK_DEPTH must be 1..8");
  end

  if (DATA_WIDTH > VP + 1) begin : gPad
    logic unusedPad;
    assign unusedPad = ^explicitWriteValue[DATA_WIDTH-1:VP+1];
  end

  pswSource_e src;
  logic doExplicit;
  logic doEntry;
  logic doExit;
  logic doSet;
  logic doClear;

  assign src        = pswSource_e'(writeDataSource);
  assign doExplicit = writeEnable && (src == SRC_EXPLICIT);
  assign doEntry    = writeEnable && (src == SRC_ENTRY);
  assign doExit     = writeEnable && (src == SRC_EXIT);
  assign doSet      = writeEnable && (src == SRC_MASK_SET);
  assign doClear    = writeEnable && (src == SRC_MASK_CLEAR);

  logic [MASK_WIDTH-1:0]     maskReg;
  logic [PRIORITY_WIDTH-1:0] prioReg;
  logic                      vReg;
  logic [STACK_DEPTH-1:0]    uStack;
  logic [STACK_DEPTH-1:0]    ieStack;
  logic [MASK_WIDTH-1:0]     operand;
  logic [LW-1:0]             level;
  logic                      ovf;
  logic                      udf;
  logic                      atTop;
  logic                      atBottom;

  assign operand  = explicitWriteValue[MASK_WIDTH-1:0];
  assign atTop    = (level == LW'(STACK_DEPTH));
  assign atBottom = (level == '0);

  psw_mode_stack #(
    .DEPTH(STACK_DEPTH)
  ) uStackInst (
    .clock    (clock),
    .reset    (reset),
    .load     (doExplicit),
    .loadValue(explicitWriteValue[UL+:STACK_DEPTH]),
    .push     (doEntry),
    .pop      (doExit),
    .value    (uStack)
  );

  psw_mode_stack #(
    .DEPTH(STACK_DEPTH)
  ) ieStackInst (
    .clock    (clock),
    .reset    (reset),
    .load     (doExplicit),
    .loadValue(explicitWriteValue[IL+:STACK_DEPTH]),
    .push     (doEntry),
    .pop      (doExit),
    .value    (ieStack)
  );

  // Flag sets are ordered after flagClear so a same-cycle set wins.
  always_ff @(posedge clock) begin
    if (!reset) begin
      maskReg <= '0;
      prioReg <= '0;
      vReg    <= 1'b0;
      level   <= '0;
      ovf     <= 1'b0;
      udf     <= 1'b0;
    end else begin
      if (flagClear) begin
        ovf <= 1'b0;
        udf <= 1'b0;
      end
      unique case (1'b1)
        doExplicit: begin
          maskReg <= operand;
          prioReg <= explicitWriteValue[PL+:PRIORITY_WIDTH];
          vReg    <= explicitWriteValue[VP];
        end
        doEntry: begin
          prioReg <= priorityWriteValue;
          if (atTop) ovf <= 1'b1;
          else level <= level + LW'(1);
        end
        doExit: begin
          if (atBottom) udf <= 1'b1;
          else level <= level - LW'(1);
        end
        doSet:   maskReg <= maskReg | operand;
        doClear: maskReg <= maskReg & ~operand;
        default: ;
      endcase
    end
  end

  logic [DATA_WIDTH-1:0] processorStatusWord;

  always_comb begin
    processorStatusWord = '0;
    processorStatusWord[MASK_WIDTH-1:0]     = maskReg;
    processorStatusWord[PL+:PRIORITY_WIDTH] = prioReg;
    processorStatusWord[IL+:STACK_DEPTH]    = ieStack;
    processorStatusWord[UL+:STACK_DEPTH]    = uStack;
    processorStatusWord[VP]                 = vReg;
  end

  assign readValue        = processorStatusWord;
  assign nestingLevel     = level;
  assign nestingOverflow  = ovf;
  assign nestingUnderflow = udf;

endmodule

// File: tb/tb_processor_status_stack.sv
// Scoreboard bench for processor_status_stack, depth 3 and depth 4 builds.
// Stimulus queues expectations; a negedge monitor pops and compares.
module tb_processor_status_stack;

  logic        clock = 1'b0;
  logic        reset;
  logic        writeEnable;
  logic [2:0]  writeDataSource;
  logic [31:0] explicitWriteValue;
  logic [4:0]  priorityWriteValue;
  logic        flagClear;

  logic [31:0] readValue3;
  logic [1:0]  level3;
  logic        ovf3;
  logic        udf3;
  logic [31:0] readValue4;
  logic [2:0]  level4;
  logic        ovf4;
  logic        udf4;

  always #5 clock = ~clock;

  processor_status_stack dut3 (
    .clock             (clock),
    .reset             (reset),
    .readValue         (readValue3),
    .writeEnable       (writeEnable),
    .writeDataSource   (writeDataSource),
    .explicitWriteValue(explicitWriteValue),
    .priorityWriteValue(priorityWriteValue),
    .flagClear         (flagClear),
    .nestingLevel      (level3),
    .nestingOverflow   (ovf3),
    .nestingUnderflow  (udf3)
  );

  processor_status_stack #(
    .STACK_DEPTH(4)
  ) dut4 (
    .clock             (clock),
    .reset             (reset),
    .readValue         (readValue4),
    .writeEnable       (writeEnable),
    .writeDataSource   (writeDataSource),
    .explicitWriteValue(explicitWriteValue),
    .priorityWriteValue(priorityWriteValue),
    .flagClear         (flagClear),
    .nestingLevel      (level4),
    .nestingOverflow   (ovf4),
    .nestingUnderflow  (udf4)
  );

  typedef struct {
    string       name;
    bit          sel;
    logic [31:0] psw;
    int          lvl;
    logic        ovf;
    logic        udf;
  } exp_t;

  exp_t expQ[$];
  int   tests = 0;
  int   fails = 0;

  always @(negedge clock) begin
    while (expQ.size() > 0) begin
      exp_t e;
      logic [31:0] aPsw;
      int          aLvl;
      logic        aOvf;
      logic        aUdf;
      e = expQ.pop_front();
      if (e.sel) begin
        aPsw = readValue4; aLvl = int'(level4);
        aOvf = ovf4;       aUdf = udf4;
      end else begin
        aPsw = readValue3; aLvl = int'(level3);
        aOvf = ovf3;       aUdf = udf3;
      end
      tests++;
      if (aPsw !== e.psw || aLvl != e.lvl ||
          aOvf !== e.ovf || aUdf !== e.udf) begin
        fails++;
        $display("FAIL %s: got psw=%h lvl=%0d ovf=%b udf=%b, want psw=%h lvl=%0d ovf=%b udf=%b",
                 e.name, aPsw, aLvl, aOvf, aUdf,
                 e.psw, e.lvl, e.ovf, e.udf);
      end
    end
  end

  task automatic exp3(input string n, input logic [31:0] p,
                      input int l, input logic o, input logic u);
    expQ.push_back('{n, 1'b0, p, l, o, u});
  endtask

  task automatic exp4(input string n, input logic [31:0] p,
                      input int l);
    expQ.push_back('{n, 1'b1, p, l, 1'b0, 1'b0});
  endtask

  // One clock with the given inputs, then back to idle.
  task automatic cyc(input logic we, input logic [2:0] s,
                     input logic [31:0] v, input logic [4:0] pr,
                     input logic fc, input logic rs);
    writeEnable        = we;
    writeDataSource    = s;
    explicitWriteValue = v;
    priorityWriteValue = pr;
    flagClear          = fc;
    reset              = rs;
    @(posedge clock);
    #1;
    writeEnable = 1'b0;
    flagClear   = 1'b0;
    reset       = 1'b1;
  endtask

  task automatic op(input logic [2:0] s, input logic [31:0] v,
                    input logic [4:0] pr);
    cyc(1'b1, s, v, pr, 1'b0, 1'b1);
  endtask

  task automatic idle();
    cyc(1'b0, 3'd0, 32'h0, 5'h0, 1'b0, 1'b1);
  endtask

  task automatic doReset();
    cyc(1'b0, 3'd0, 32'h0, 5'h0, 1'b0, 1'b0);
  endtask

  localparam logic [2:0] EXPL = 3'd0;
  localparam logic [2:0] ENTR = 3'd1;
  localparam logic [2:0] EXIT = 3'd2;
  localparam logic [2:0] MSET = 3'd3;
  localparam logic [2:0] MCLR = 3'd4;

  initial begin
    writeEnable        = 1'b0;
    writeDataSource    = 3'd0;
    explicitWriteValue = 32'h0;
    priorityWriteValue = 5'h0;
    flagClear          = 1'b0;
    reset              = 1'b0;
    @(posedge clock);
    #1;
    doReset();
    exp3("reset3", 32'h0, 0, 1'b0, 1'b0);
    exp4("reset4", 32'h0, 0);

    // Explicit write, pad bits dropped, then hold.
    op(EXPL, 32'hABCD1234, 5'h0);
    exp3("explicit", 32'h0BCD1234, 0, 1'b0, 1'b0);
    idle();
    exp3("hold1", 32'h0BCD1234, 0, 1'b0, 1'b0);
    idle();
    exp3("hold2", 32'h0BCD1234, 0, 1'b0, 1'b0);

    // V=1 U=101 IE=110 prio=01100 mask=C4EA
    op(EXPL, 32'h0DCCC4EA, 5'h0);
    exp3("load2", 32'h0DCCC4EA, 0, 1'b0, 1'b0);
    op(ENTR, 32'h0, 5'b10101);
    exp3("entry", 32'h0A75C4EA, 1, 1'b0, 1'b0);
    op(EXPL, 32'h0DCCC4EA, 5'h0);
    exp3("reload", 32'h0DCCC4EA, 1, 1'b0, 1'b0);
    op(EXIT, 32'h0, 5'h1F);
    exp3("exit", 32'h0B8CC4EA, 0, 1'b0, 1'b0);

    // Nesting counter and sticky flags.
    doReset();
    op(ENTR, 32'h0, 5'h0);
    exp3("nest1", 32'h0, 1, 1'b0, 1'b0);
    op(ENTR, 32'h0, 5'h0);
    exp3("nest2", 32'h0, 2, 1'b0, 1'b0);
    op(ENTR, 32'h0, 5'h0);
    exp3("nest3", 32'h0, 3, 1'b0, 1'b0);
    op(ENTR, 32'h0, 5'h0);
    exp3("overflow", 32'h0, 3, 1'b1, 1'b0);
    op(EXIT, 32'h0, 5'h0);
    exp3("unnest2", 32'h0, 2, 1'b1, 1'b0);
    op(EXIT, 32'h0, 5'h0);
    exp3("unnest1", 32'h0, 1, 1'b1, 1'b0);
    op(EXIT, 32'h0, 5'h0);
    exp3("unnest0", 32'h0, 0, 1'b1, 1'b0);
    op(EXIT, 32'h0, 5'h0);
    exp3("underflow", 32'h0, 0, 1'b1, 1'b1);
    cyc(1'b0, 3'd0, 32'h0, 5'h0, 1'b1, 1'b1);
    exp3("flagclear", 32'h0, 0, 1'b0, 1'b0);
    cyc(1'b1, EXIT, 32'h0, 5'h0, 1'b1, 1'b1);
    exp3("udfWinsClr", 32'h0, 0, 1'b0, 1'b1);
    cyc(1'b0, 3'd0, 32'h0, 5'h0, 1'b1, 1'b1);
    exp3("flagclear2", 32'h0, 0, 1'b0, 1'b0);

    // Mask set/clear, upper operand bits ignored.
    op(EXPL, 32'h0DCC00F0, 5'h0);
    exp3("maskload", 32'h0DCC00F0, 0, 1'b0, 1'b0);
    op(MSET, 32'hFFFF0F00, 5'h1F);
    exp3("maskset", 32'h0DCC0FF0, 0, 1'b0, 1'b0);
    op(MCLR, 32'h123400F0, 5'h1F);
    exp3("maskclr", 32'h0DCC0F00, 0, 1'b0, 1'b0);

    // Enter to level 3 and collide overflow with flagClear.
    op(ENTR, 32'h0, 5'h0);
    exp3("e1", 32'h0A600F00, 1, 1'b0, 1'b0);
    op(ENTR, 32'h0, 5'h0);
    exp3("e2", 32'h09200F00, 2, 1'b0, 1'b0);
    op(ENTR, 32'h0, 5'h0);
    exp3("e3", 32'h08000F00, 3, 1'b0, 1'b0);
    cyc(1'b1, ENTR, 32'h0, 5'h0, 1'b1, 1'b1);
    exp3("ovfWinsClr", 32'h08000F00, 3, 1'b1, 1'b0);
    cyc(1'b1, ENTR, 32'h0, 5'h07, 1'b0, 1'b0);
    exp3("resetInEntry", 32'h0, 0, 1'b0, 1'b0);
    op(EXPL, 32'h0DCCC4EA, 5'h0);
    exp3("load5", 32'h0DCCC4EA, 0, 1'b0, 1'b0);
    op(3'd6, 32'hFFFFFFFF, 5'h1F);
    exp3("reserved6", 32'h0DCCC4EA, 0, 1'b0, 1'b0);
    op(3'd7, 32'h0, 5'h1F);
    exp3("reserved7", 32'h0DCCC4EA, 0, 1'b0, 1'b0);

    // Depth 4: V=29, U=28:25, IE=24:21, prio=20:16.
    doReset();
    op(EXPL, 32'h36005A5A, 5'h0);
    exp4("d4load", 32'h36005A5A, 0);
    op(ENTR, 32'h0, 5'h0);
    exp4("d4entry", 32'h2A005A5A, 1);
    op(EXIT, 32'h0, 5'h0);
    exp4("d4exit", 32'h36005A5A, 0);

    for (int i = 0; i < 10 && expQ.size() > 0; i++) begin
      @(posedge clock);
    end
    if (expQ.size() > 0) begin
      fails++;
      $display("FAIL drain: got %0d pending, want 0", expQ.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
